mc_config_loader: RTL and testbench

- Serial configuration writer for the macrocell array: receives a bit-serial fuse stream and drives the per-macrocell `_mux` configuration bits that each macrocell core consumes.
- Data is staged in a shadow register, checked with CRC-8, then committed atomically to the active configuration.
- Supports readback of the active configuration on a serial output, so a bench can verify programming end to end.

---
 rtl/mc_config_loader_pkg.sv | 45 ++++
 rtl/mc_config_loader_if.sv | 25 ++
 rtl/mc_config_loader_crc8.sv | 18 +
 rtl/mc_config_loader.sv | 146 ++++++++++++++
 tb/tb_mc_config_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_config_loader_pkg.sv
// Shared constants, field map and state encoding for the macrocell config loader.
package mc_config_loader_pkg;

    localparam int CFG_BITS = 20;
    localparam int NUM_MC_DEF = 16;

    // Per-macrocell field map, bit 0 upward
    localparam int PT1_IDX      = 0;
    localparam int PT2_IDX      = 1;
    localparam int PT3_IDX      = 2;
    localparam int PT4_IDX      = 3;
    localparam int PT5_IDX      = 4;
    localparam int GCLR_IDX     = 5;
    localparam int PT4_FUNC_IDX = 6;
    localparam int PT5_FUNC_IDX = 7;
    localparam int XOR_A_IDX    = 8;
    localparam int XOR_B_IDX    = 9;
    localparam int XOR_INV_IDX  = 10;
    localparam int D_IDX        = 11;
    localparam int STORAGE_IDX  = 12;
    localparam int FB_IDX       = 13;
    localparam int O_IDX        = 14;
    localparam int OE_MUX_IDX   = 15;
    localparam int OE_MUX_W     = 3;
    localparam int GCLK_IDX     = 18;
    localparam int GCLK_W       = 2;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_READ,
        ST_RDCRC
    } state_t;

    // One bit-serial CRC-8 step, MSB-first, no reflection
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mc_config_loader_if.sv
// Frame control, serial stream and status bundle of the config loader.
interface mc_config_loader_if #(parameter int W = 320);
    logic         load_start_v;
    logic         rb_start_v;
    logic         abort_v;
    logic         sdi_v;
    logic         sdi_valid_v;
    logic         sdo_v;
    logic         sdo_valid_v;
    logic         busy_v;
    logic         done_v;
    logic         err_v;
    logic         cfg_valid_v;
    logic [W-1:0] cfg_v;

    modport master (
        output load_start_v, rb_start_v, abort_v, sdi_v, sdi_valid_v,
        input  sdo_v, sdo_valid_v, busy_v, done_v, err_v, cfg_valid_v, cfg_v
    );

    modport slave (
        input  load_start_v, rb_start_v, abort_v, sdi_v, sdi_valid_v,
        output sdo_v, sdo_valid_v, busy_v, done_v, err_v, cfg_valid_v, cfg_v
    );
endinterface

// File: rtl/mc_config_loader_crc8.sv
// Bit-serial CRC-8 accumulator, shared by load and readback.
module crc8_serial
    import mc_config_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);
    // Clear takes priority so a new frame always starts from 0x00
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc <= 8'h00;
        else if (clr) crc <= 8'h00;
        else if (en)  crc <= crc8_step(crc, bit_in);
    end
endmodule

// File: rtl/mc_config_loader.sv
// Serial config writer: shadow load + CRC check + atomic commit, and readback.
module mc_config_loader
    import mc_config_loader_pkg::*;
#(
    parameter int NUM_MC = NUM_MC_DEF
) (
    input logic               clk_v,
    input logic               rst_v,
    mc_config_loader_if.slave bus
);
    localparam int N  = NUM_MC * CFG_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state, nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     tcnt;
    logic [7:0]     trailer, trl_full, crc;
    logic [N-1:0]   shadow, cfg;
    logic           cfg_valid, done, err;
    logic           crc_clr, crc_en, crc_bit, commit, fail, rd_end;

    crc8_serial u_crc (
        .clk    (clk_v),
        .rst    (rst_v),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // State register
    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) state <= ST_IDLE;
        else       state <= nxt;
    end

    // Next state and per-cycle control; abort overrides everything
    always_comb begin
        nxt      = state;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_bit  = 1'b0;
        commit   = 1'b0;
        fail     = 1'b0;
        rd_end   = 1'b0;
        trl_full = {trailer[6:0], bus.sdi_v};
        unique case (state)
            ST_IDLE: begin
                if (bus.load_start_v) begin
                    nxt     = ST_LOAD;
                    crc_clr = 1'b1;
                end else if (bus.rb_start_v) begin
                    nxt     = ST_READ;
                    crc_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.sdi_valid_v) begin
                    crc_en  = 1'b1;
                    crc_bit = bus.sdi_v;
                    if (cnt == LAST) nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.sdi_valid_v && tcnt == 3'd7) begin
                    nxt = ST_IDLE;
                    if (trl_full == crc) commit = 1'b1;
                    else                 fail   = 1'b1;
                end
            end
            ST_READ: begin
                crc_en  = 1'b1;
                crc_bit = cfg[cnt];
                if (cnt == LAST) nxt = ST_RDCRC;
            end
            ST_RDCRC: begin
                if (tcnt == 3'd7) begin
                    nxt    = ST_IDLE;
                    rd_end = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        if (bus.abort_v && state != ST_IDLE) begin
            nxt    = ST_IDLE;
            crc_en = 1'b0;
            commit = 1'b0;
            fail   = 1'b0;
            rd_end = 1'b0;
        end
    end

    // Counters, shadow staging, commit and status pulses
    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            cnt       <= '0;
            tcnt      <= '0;
            trailer   <= '0;
            shadow    <= '0;
            cfg       <= '0;
            cfg_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= commit | rd_end;
            err  <= fail;
            if (commit) begin
                cfg       <= shadow;
                cfg_valid <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    cnt  <= '0;
                    tcnt <= '0;
                end
                ST_LOAD: if (bus.sdi_valid_v) begin
                    shadow[cnt] <= bus.sdi_v;
                    cnt         <= cnt + 1'b1;
                end
                ST_CHECK: if (bus.sdi_valid_v) begin
                    trailer <= trl_full;
                    tcnt    <= tcnt + 1'b1;
                end
                ST_READ:  cnt  <= cnt + 1'b1;
                ST_RDCRC: tcnt <= tcnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Readback streams cfg in stream order, then the CRC MSB first
    always_comb begin
        bus.sdo_v = 1'b0;
        if (state == ST_READ)       bus.sdo_v = cfg[cnt];
        else if (state == ST_RDCRC) bus.sdo_v = crc[3'd7 - tcnt];
    end

    assign bus.sdo_valid_v = (state == ST_READ) || (state == ST_RDCRC);
    assign bus.busy_v      = (state != ST_IDLE);
    assign bus.done_v      = done;
    assign bus.err_v       = err;
    assign bus.cfg_valid_v = cfg_valid;
    assign bus.cfg_v       = cfg;

endmodule

// File: tb/tb_mc_config_loader.sv
// Scoreboard bench: stimulus pushes expected done/err/sdo events, monitor pops on each output.
module tb_mc_config_loader;
    localparam int N = 320;
    localparam int EV_DONE = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_SDO  = 2;

    typedef struct {
        int   kind;
        logic b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ev_t  q[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    mc_config_loader_if #(.W(N)) bus ();

    mc_config_loader #(.NUM_MC(16)) dut (
        .clk_v (clk),
        .rst_v (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] crc_of(input logic [N-1:0] d);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < N; i++) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic b);
        ev_t e;
        e.kind = kind;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic b);
        ev_t e;
        vec_cnt++;
        if (q.size() == 0) begin
            miss_cnt++;
            $display("FAIL unexpected_event: got kind %0d bit %0b expected none", kind, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == EV_SDO && e.b !== b)) begin
                miss_cnt++;
                $display("FAIL event_order: got kind %0d bit %0b expected kind %0d bit %0b",
                         kind, b, e.kind, e.b);
            end
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done_v)      pop_check(EV_DONE, 1'b0);
            if (bus.err_v)       pop_check(EV_ERR, 1'b0);
            if (bus.sdo_valid_v) pop_check(EV_SDO, bus.sdo_v);
        end
    end

    task automatic send_frame(input logic [N-1:0] d, input logic [7:0] trl,
                              input int stall_at, input int abort_at,
                              input int restart_at, input bit both);
        if (abort_at < 0) push((trl == crc_of(d)) ? EV_DONE : EV_ERR, 1'b0);
        @(posedge clk); #1;
        bus.load_start_v = 1'b1;
        bus.rb_start_v   = both;
        @(posedge clk); #1;
        bus.load_start_v = 1'b0;
        bus.rb_start_v   = 1'b0;
        if (both) begin
            chk("collision_busy", N'(bus.busy_v), N'(1));
            chk("collision_no_sdo", N'(bus.sdo_valid_v), N'(0));
        end
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                bus.sdi_valid_v = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                chk("stall_busy", N'(bus.busy_v), N'(1));
            end
            if (i == abort_at) begin
                bus.sdi_valid_v = 1'b0;
                bus.abort_v     = 1'b1;
                @(posedge clk); #1;
                bus.abort_v = 1'b0;
                chk("abort_idle", N'(bus.busy_v), N'(0));
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            bus.sdi_v        = d[i];
            bus.sdi_valid_v  = 1'b1;
            bus.load_start_v = (i == restart_at);
            @(posedge clk); #1;
            bus.load_start_v = 1'b0;
        end
        for (int j = 7; j >= 0; j--) begin
            bus.sdi_v       = trl[j];
            bus.sdi_valid_v = 1'b1;
            @(posedge clk); #1;
        end
        bus.sdi_valid_v = 1'b0;
        bus.sdi_v       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("frame_idle", N'(bus.busy_v), N'(0));
        chk("frame_events_drained", N'(q.size()), N'(0));
    endtask

    task automatic readback(input logic [N-1:0] exp_cfg, input int reset_after);
        logic [7:0] c;
        c = crc_of(exp_cfg);
        for (int i = 0; i < N; i++) push(EV_SDO, exp_cfg[i]);
        for (int j = 7; j >= 0; j--) push(EV_SDO, c[j]);
        push(EV_DONE, 1'b0);
        @(posedge clk); #1;
        bus.rb_start_v = 1'b1;
        @(posedge clk); #1;
        bus.rb_start_v = 1'b0;
        chk("rb_first_valid", N'(bus.sdo_valid_v), N'(1));
        if (reset_after >= 0) begin
            repeat (reset_after) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_sdo_valid", N'(bus.sdo_valid_v), N'(0));
            chk("arst_busy", N'(bus.busy_v), N'(0));
            chk("arst_cfg_valid", N'(bus.cfg_valid_v), N'(0));
            chk("arst_cfg", bus.cfg_v, '0);
            q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        repeat (N + 8 + 1) @(posedge clk);
        #1;
        chk("rb_idle", N'(bus.busy_v), N'(0));
        chk("rb_events_drained", N'(q.size()), N'(0));
    endtask

    initial begin
        logic [N-1:0] zero, d21, da, db;
        logic [7:0]   c21;
        zero = '0;
        d21  = '0;
        d21[21] = 1'b1;
        da = '0;
        da[0]   = 1'b1;
        da[150] = 1'b1;
        da[319] = 1'b1;
        db = ~da;
        db[77] = 1'b0;
        c21 = crc_of(d21);

        bus.load_start_v = 1'b0;
        bus.rb_start_v   = 1'b0;
        bus.abort_v      = 1'b0;
        bus.sdi_v        = 1'b0;
        bus.sdi_valid_v  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", N'(bus.busy_v), N'(0));
        chk("reset_cfg", bus.cfg_v, '0);
        chk("reset_cfg_valid", N'(bus.cfg_valid_v), N'(0));
        chk("reset_sdo_valid", N'(bus.sdo_valid_v), N'(0));
        chk("reset_done_err", N'({bus.done_v, bus.err_v}), N'(0));
        rst = 1'b0;

        // All-zero load with matching trailer
        send_frame(zero, 8'h00, -1, -1, -1, 1'b0);
        chk("zero_cfg", bus.cfg_v, zero);
        chk("zero_cfg_valid", N'(bus.cfg_valid_v), N'(1));

        // Same data, wrong trailer
        send_frame(zero, 8'h01, -1, -1, -1, 1'b0);
        chk("badcrc_cfg", bus.cfg_v, zero);
        chk("badcrc_cfg_valid", N'(bus.cfg_valid_v), N'(1));

        // Single bit: macrocell 1 pt2, then read it back
        send_frame(d21, c21, -1, -1, -1, 1'b0);
        chk("bit21_cfg", bus.cfg_v, d21);
        readback(d21, -1);

        // Mid-frame stall, counter must hold for the commit to land
        send_frame(da, crc_of(da), 150, -1, -1, 1'b0);
        chk("stall_cfg", bus.cfg_v, da);

        // Abort keeps the prior active config
        send_frame(db, crc_of(db), -1, 100, -1, 1'b0);
        chk("abort_cfg", bus.cfg_v, da);
        chk("abort_no_events", N'(q.size()), N'(0));

        // Both starts together, then a restart pulse mid-LOAD that must be ignored
        send_frame(db, crc_of(db), -1, -1, 50, 1'b1);
        chk("collision_cfg", bus.cfg_v, db);

        // Async reset in the middle of a readback
        readback(db, 30);
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_cfg", bus.cfg_v, '0);
        chk("post_reset_queue", N'(q.size()), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
